debounced_logic_unit: RTL

DEBOUNCED_LOGIC_UNIT -- requirements
Module: debounced_logic_unit

---
 rtl/debounced_logic_unit_if.sv | 30 +++
 rtl/debounced_logic_unit.sv | 97 +++++++++
 2 files changed

// File: rtl/debounced_logic_unit_if.sv
// Switch-side bundle for the debounced logic unit: raw operands/select in, registered result and status out.
// Master drives the raw switch inputs; slave is the logic unit that produces out/out_valid/out_changed.
interface debounced_logic_unit_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] sw0;
  logic [WIDTH-1:0] sw1;
  logic [2:0]       select;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_changed;

  modport master (
    output sw0,
    output sw1,
    output select,
    input  out,
    input  out_valid,
    input  out_changed
  );

  modport slave (
    input  sw0,
    input  sw1,
    input  select,
    output out,
    output out_valid,
    output out_changed
  );
endinterface

// File: rtl/debounced_logic_unit.sv
// Synchronizes and debounces every switch bit, then registers the selected bitwise op; free-running, no backpressure.
// Latency: a raw change stable from edge N reaches deb at N+DEBOUNCE_CYCLES+1 and out at N+DEBOUNCE_CYCLES+2.
module debounced_logic_unit #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  debounced_logic_unit_if.slave bus
);

  // Operands and select are debounced as one flat vector: {select, sw1, sw0}.
  localparam int NB = 2 * WIDTH + 3;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef logic [CW-1:0] cnt_t;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    s1_q, s1_d;
  logic [NB-1:0]    s2_q, s2_d;
  logic [NB-1:0]    deb_q, deb_d;
  cnt_t [NB-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             out_changed_q, out_changed_d;

  assign raw = {bus.select, bus.sw1, bus.sw0};

  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign op_a   = deb_q[WIDTH-1:0];
  assign op_b   = deb_q[2*WIDTH-1:WIDTH];
  assign op_sel = deb_q[NB-1:2*WIDTH];

  always_comb begin
    out_d = '0;
    case (op_sel)
      3'b000:  out_d = ~op_a;
      3'b001:  out_d = op_a;
      3'b010:  out_d = ~(op_a ^ op_b);
      3'b011:  out_d = op_a & op_b;
      3'b100:  out_d = op_a | op_b;
      3'b101:  out_d = op_a ^ op_b;
      3'b110:  out_d = ~(op_a & op_b);
      3'b111:  out_d = ~(op_a | op_b);
      default: out_d = '0;
    endcase
  end

  // Valid means nothing is mid-debounce; any bit still disagreeing keeps it low.
  assign out_valid_d   = (s2_q == deb_q);
  assign out_changed_d = (out_d != out_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      deb_q         <= '0;
      cnt_q         <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      out_changed_q <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      deb_q         <= deb_d;
      cnt_q         <= cnt_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      out_changed_q <= out_changed_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_changed = out_changed_q;

endmodule
